// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port: LSU has fixed
// priority, ALU is guaranteed a grant after MAX_WAIT consecutive denials.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [31:0] pend
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  logic [CW-1:0] r_cnt;
  logic          r_we3;
  logic [4:0]    r_a3;
  logic [31:0]   r_wd3;

  logic          w_starved;
  logic          w_alu_gnt;
  logic          w_mem_gnt;
  logic          w_fire;
  wb_req_t       w_sel;
  logic [31:0]   w_pend;

  // ALU overrides LSU priority once it has been denied MAX_WAIT cycles in a row
  assign w_starved = (r_cnt >= CW'(MAX_WAIT));
  assign w_alu_gnt = !reset && alu_valid && (!mem_valid || w_starved);
  assign w_mem_gnt = !reset && mem_valid && !(alu_valid && w_starved);
  assign w_fire    = w_alu_gnt || w_mem_gnt;

  always_comb begin
    w_sel = '0;
    if (w_alu_gnt) w_sel = '{rd: alu_rd, data: alu_data};
    else if (w_mem_gnt) w_sel = '{rd: mem_rd, data: mem_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
      r_cnt <= '0;
    end else begin
      r_we3 <= w_fire && (w_sel.rd != 5'd0);
      if (w_fire) begin
        r_a3  <= w_sel.rd;
        r_wd3 <= w_sel.data;
      end
      if (!alu_valid || w_alu_gnt) r_cnt <= '0;
      else if (!w_starved)         r_cnt <= r_cnt + CW'(1);
    end
  end

  // x0 is hardwired, so it never shows as pending
  always_comb begin
    w_pend = '0;
    for (int r = 1; r < 32; r++) begin
      w_pend[r] = (alu_valid && (alu_rd == 5'(r))) ||
                  (mem_valid && (mem_rd == 5'(r))) ||
                  (r_we3 && (r_a3 == 5'(r)));
    end
  end

  assign alu_ready = w_alu_gnt;
  assign mem_ready = w_mem_gnt;
  assign we3       = r_we3;
  assign a3        = r_a3;
  assign wd3       = r_wd3;
  assign pend      = w_pend;

endmodule
